// File: rtl/auth_ctrl_if.sv
// UART receive handshake: the byte receiver drives data/ready (master) and
// auth_ctrl consumes bytes with a one-cycle clear pulse (slave).
interface auth_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rx_rdy;

  modport master (output rx_data, output rx_rdy, input clr_rx_rdy);
  modport slave  (input rx_data, input rx_rdy, output clr_rx_rdy);
endinterface

// File: rtl/auth_ctrl.sv
// Rider-authentication controller: IDLE / CONNECTED / DISCONNECTED power-path FSM
// with rider-off debounce; the link-loss watchdog is built only when AUTH_LINK_WDOG_EN is defined.
module auth_ctrl #(
  parameter logic [7:0]  GO_CODE       = 8'h47,
  parameter logic [7:0]  STOP_CODE     = 8'h53,
  parameter int unsigned RIDER_OFF_CYC = 1024,
  parameter int unsigned TIMEOUT_CYC   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  auth_ctrl_if.slave rx,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [1:0] auth_state,
  output logic       link_lost
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONN = 2'd1,
    S_DISC = 2'd2
  } state_e;

  if (GO_CODE == STOP_CODE) begin : g_bad_codes
    $error("auth_ctrl: GO_CODE and STOP_CODE must be distinct");
  end
  if (RIDER_OFF_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_counts
    $error("auth_ctrl: RIDER_OFF_CYC must be >= 1 and TIMEOUT_CYC >= 2");
  end

  localparam int unsigned     RO_W   = $clog2(RIDER_OFF_CYC + 1);
  localparam logic [RO_W-1:0] RO_MAX = RO_W'(RIDER_OFF_CYC);

  logic            consume, go, stop, roff_db, wd_expire;
  logic [RO_W-1:0] roff_cnt_q, roff_cnt_d;
  state_e          state_q, state_d;
  logic            pwr_up_q;

  // Every pending byte is consumed so the receiver never stalls.
  assign consume       = rx.rx_rdy;
  assign rx.clr_rx_rdy = consume;
  assign go            = consume && (rx.rx_data == GO_CODE);
  assign stop          = consume && (rx.rx_data == STOP_CODE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    roff_cnt_d = '0;
    if (rider_off) begin
      roff_cnt_d = (roff_cnt_q == RO_MAX) ? roff_cnt_q : roff_cnt_q + RO_W'(1);
    end
  end
  assign roff_db = (roff_cnt_q == RO_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_CONN;
      S_CONN: begin
        if (stop)           state_d = roff_db ? S_IDLE : S_DISC;
        else if (wd_expire) state_d = S_DISC;
      end
      // Rider stepping off wins over a simultaneous re-authentication.
      S_DISC: begin
        if (roff_db) state_d = S_IDLE;
        else if (go) state_d = S_CONN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      roff_cnt_q <= '0;
      pwr_up_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      roff_cnt_q <= roff_cnt_d;
      pwr_up_q   <= (state_d != S_IDLE);
    end
  end

  assign pwr_up     = pwr_up_q;
  assign auth_state = state_q;

`ifdef AUTH_LINK_WDOG_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            link_lost_q, link_lost_d;

  assign wd_expire = (state_q == S_CONN) && (wd_q == WD_LAST) && !consume;

  // Counts only while staying in CONNECTED through a silent cycle; entry, any byte and exit all clear it.
  always_comb begin
    wd_d = '0;
    if (state_q == S_CONN && state_d == S_CONN && !consume) wd_d = wd_q + WD_W'(1);
    link_lost_d = link_lost_q;
    if (go)             link_lost_d = 1'b0;
    else if (wd_expire) link_lost_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q        <= '0;
      link_lost_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      link_lost_q <= link_lost_d;
    end
  end

  assign link_lost = link_lost_q;
`else
  assign wd_expire = 1'b0;
  assign link_lost = 1'b0;
`endif

endmodule

// File: tb/tb_auth_ctrl.sv
// Directed bench for auth_ctrl with RIDER_OFF_CYC=4, TIMEOUT_CYC=100: a vector table for
// single-cycle behaviour plus hand sequences for the watchdog and asynchronous reset.
module tb_auth_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rider_off;
  logic       pwr_up;
  logic [1:0] auth_state;
  logic       link_lost;

  int total = 0;
  int bad   = 0;

  auth_ctrl_if rx_if ();

  auth_ctrl #(
    .GO_CODE       (8'h47),
    .STOP_CODE     (8'h53),
    .RIDER_OFF_CYC (4),
    .TIMEOUT_CYC   (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx_if),
    .rider_off  (rider_off),
    .pwr_up     (pwr_up),
    .auth_state (auth_state),
    .link_lost  (link_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       roff;
    logic       exp_clr;
    logic       exp_pwr;
    logic [1:0] exp_st;
    logic       exp_ll;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic [7:0] data, logic roff,
                              logic clr, logic pwr, logic [1:0] st, logic ll);
    vec_t v;
    v.rdy = rdy; v.data = data; v.roff = roff;
    v.exp_clr = clr; v.exp_pwr = pwr; v.exp_st = st; v.exp_ll = ll;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; registered outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_if.rx_rdy = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_if.rx_rdy  = 1'b1;
    rx_if.rx_data = b;
    step();
    rx_if.rx_rdy  = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic pwr, input logic [1:0] st, input logic ll);
    check({tag, " pwr_up"},     32'(pwr_up),     32'(pwr));
    check({tag, " auth_state"}, 32'(auth_state), 32'(st));
    check({tag, " link_lost"},  32'(link_lost),  32'(ll));
  endtask

  initial begin
    rst_n         = 1'b0;
    rider_off     = 1'b0;
    rx_if.rx_rdy  = 1'b0;
    rx_if.rx_data = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 1'b0, 2'd0, 1'b0);
    check("reset clr_rx_rdy", 32'(rx_if.clr_rx_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_regs("post_reset", 1'b0, 2'd0, 1'b0);

    //                  rdy  data   roff clr pwr st    ll
    vecs.push_back(mk(1, 8'h00, 0,   1,  0,  2'd0, 0)); // filter 00 in IDLE
    vecs.push_back(mk(1, 8'h53, 0,   1,  0,  2'd0, 0)); // STOP ignored in IDLE
    vecs.push_back(mk(1, 8'hFF, 0,   1,  0,  2'd0, 0)); // filter FF
    vecs.push_back(mk(0, 8'h47, 0,   0,  0,  2'd0, 0)); // GO data without rdy
    vecs.push_back(mk(1, 8'h47, 0,   1,  1,  2'd1, 0)); // power-up
    vecs.push_back(mk(0, 8'h00, 0,   0,  1,  2'd1, 0));
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd1, 0)); // rider_off 3 cycles
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd1, 0));
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd1, 0));
    vecs.push_back(mk(0, 8'h00, 0,   0,  1,  2'd1, 0)); // released: counter clears
    vecs.push_back(mk(1, 8'h53, 0,   1,  1,  2'd2, 0)); // STOP -> DISCONNECTED
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // rider_off rises (cnt 1)
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 2
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 3
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 4, db high next cycle
    vecs.push_back(mk(0, 8'h00, 1,   0,  0,  2'd0, 0)); // -> IDLE, power off
    vecs.push_back(mk(1, 8'h47, 1,   1,  1,  2'd1, 0)); // GO in IDLE despite rider_off
    vecs.push_back(mk(1, 8'h53, 1,   1,  0,  2'd0, 0)); // STOP with db high -> IDLE
    vecs.push_back(mk(1, 8'h47, 0,   1,  1,  2'd1, 0));
    vecs.push_back(mk(1, 8'h53, 0,   1,  1,  2'd2, 0));
    vecs.push_back(mk(1, 8'h47, 1,   1,  1,  2'd1, 0)); // GO in DISC, db low
    vecs.push_back(mk(1, 8'h53, 1,   1,  1,  2'd2, 0)); // cnt 1 -> DISC
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 2
    vecs.push_back(mk(1, 8'h47, 1,   1,  1,  2'd1, 0)); // cnt 3: GO still wins
    vecs.push_back(mk(1, 8'h53, 1,   1,  0,  2'd0, 0)); // cnt 4: STOP -> IDLE
    vecs.push_back(mk(1, 8'h47, 0,   1,  1,  2'd1, 0)); // cnt clears
    vecs.push_back(mk(1, 8'h53, 1,   1,  1,  2'd2, 0)); // cnt 1
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 2
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 3
    vecs.push_back(mk(0, 8'h00, 1,   0,  1,  2'd2, 0)); // cnt 4
    vecs.push_back(mk(1, 8'h47, 1,   1,  0,  2'd0, 0)); // db beats simultaneous GO

    foreach (vecs[i]) begin
      rx_if.rx_rdy  = vecs[i].rdy;
      rx_if.rx_data = vecs[i].data;
      rider_off     = vecs[i].roff;
      #1;
      check($sformatf("vec%0d clr_rx_rdy", i), 32'(rx_if.clr_rx_rdy), 32'(vecs[i].exp_clr));
      step();
      check_regs($sformatf("vec%0d", i), vecs[i].exp_pwr, vecs[i].exp_st, vecs[i].exp_ll);
    end
    rx_if.rx_rdy = 1'b0;
    rider_off    = 1'b0;
    step();

`ifdef AUTH_LINK_WDOG_EN
    // Watchdog: entry cycle counts as the first silent cycle.
    send(8'h47);
    check_regs("wd_entry", 1'b1, 2'd1, 1'b0);
    idle(99);
    check_regs("wd_99_silent", 1'b1, 2'd1, 1'b0);
    idle(1);
    check_regs("wd_expired", 1'b1, 2'd2, 1'b1);
    send(8'h00);
    check_regs("wd_sticky", 1'b1, 2'd2, 1'b1);
    send(8'h47);
    check_regs("wd_go_clears", 1'b1, 2'd1, 1'b0);
    idle(99);
    send(8'h00);
    check_regs("wd_byte_cancels", 1'b1, 2'd1, 1'b0);
    idle(99);
    check_regs("wd_restart_99", 1'b1, 2'd1, 1'b0);
    idle(1);
    check_regs("wd_restart_expired", 1'b1, 2'd2, 1'b1);
    send(8'h47);
    idle(99);
    send(8'h53);
    check_regs("wd_stop_in_expiry", 1'b1, 2'd2, 1'b0);
    idle(150);
    check_regs("wd_held_in_disc", 1'b1, 2'd2, 1'b0);
`else
    send(8'h47);
    idle(150);
    check_regs("nowd_stays_conn", 1'b1, 2'd1, 1'b0);
    send(8'h53);
    check_regs("nowd_stop", 1'b1, 2'd2, 1'b0);
`endif
    rider_off = 1'b1;
    repeat (5) step();
    rider_off = 1'b0;
    check_regs("back_to_idle", 1'b0, 2'd0, 1'b0);

    // Reset mid-session drops power asynchronously.
    send(8'h47);
    check_regs("rst_pre", 1'b1, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async pwr_up", 32'(pwr_up), 32'd0);
    check("rst_async auth_state", 32'(auth_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_regs("rst_release", 1'b0, 2'd0, 1'b0);
    idle(3);
    check_regs("rst_needs_go", 1'b0, 2'd0, 1'b0);
    send(8'h47);
    check_regs("rst_new_go", 1'b1, 2'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/auth_ctrl.md
# auth_ctrl

Parametrised rider-authentication controller for the segway power path. It consumes bytes from the Bluetooth UART receiver and debounces the rider-off indication. It drives `pwr_up` to the rest of the segway through an IDLE / CONNECTED / DISCONNECTED state machine. Relative to the first-generation authentication block, it adds configurable command codes, consumption of every received byte, rider-off debounce and an optional link-loss watchdog.

## Interface
- `GO_CODE`, default `8'h47`: byte that authenticates and powers up.
- `STOP_CODE`, default `8'h53`: byte that requests shutdown.
- `RIDER_OFF_CYC`, default `1024`: consecutive cycles `rider_off` must be high before it is acted on. Legal range is 1 or more.
- `TIMEOUT_CYC`, default `50_000_000`: cycles without any received byte in CONNECTED before the link is declared lost. Legal range is 2 or more.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  byte from the UART receiver. Valid while `rx_rdy` is high.
- `rx_rdy`  in  1  UART receiver has a byte pending.
- `clr_rx_rdy`  out  1  one-cycle pulse that consumes the pending byte.
- `rider_off`  in  1  raw rider-off indication, synchronous to `clk`.
- `pwr_up`  out  1  power enable to the segway.
- `auth_state`  out  2  current state: 0 = IDLE, 1 = CONNECTED, 2 = DISCONNECTED. Encoding 3 is never produced.
- `link_lost`  out  1  sticky flag meaning the watchdog fired since the last GO.

## Operation
- **Byte consumption:** every cycle in which `rx_rdy` is high, `clr_rx_rdy` is asserted combinationally. Every byte is consumed, including non-matching ones, so the receiver never stalls. Non-matching bytes have no effect other than kicking the watchdog.
- **GO and STOP:**
  - A GO is a consumed byte equal to `GO_CODE`.
  - A STOP is a consumed byte equal to `STOP_CODE`.
- **Rider-off debounce (`roff_db`):**
  - A saturating counter increments while `rider_off` is high and clears to 0 in any cycle `rider_off` is low.
  - `roff_db` is high when the counter equals `RIDER_OFF_CYC`.
- **State transitions:**
  - IDLE: GO goes to CONNECTED. Everything else stays in IDLE.
  - CONNECTED, STOP with `roff_db` high: go to IDLE.
  - CONNECTED, STOP with `roff_db` low: go to DISCONNECTED.
  - CONNECTED, watchdog expiry with no byte consumed that cycle: go to DISCONNECTED and set `link_lost`.
  - CONNECTED, any other input: stay in CONNECTED.
  - DISCONNECTED, `roff_db` high: go to IDLE. This takes priority over a simultaneous GO.
  - DISCONNECTED, GO: go to CONNECTED.
- **Power output:** `pwr_up` is registered and equals (next state != IDLE).
- **Watchdog counter:**
  - Width is `$clog2(TIMEOUT_CYC)`.
  - Clears on entry to CONNECTED and in any cycle a byte is consumed.
  - Increments each cycle in CONNECTED otherwise.
  - Expiry is the counter equal to `TIMEOUT_CYC-1` with no byte consumed that cycle.
  - Held at 0 in IDLE and DISCONNECTED.
- **`link_lost`:** set on watchdog expiry. Cleared when a GO is consumed in any state.
- **Simultaneous events:**
  - A byte consumed in the expiry cycle cancels the expiry. A STOP in that cycle is processed as a normal STOP.
  - GO and STOP are distinct codes. Equal parameter values are illegal; guard them with an elaboration-time check.

## Timing
- **Reset values:** state IDLE, `pwr_up` 0, `link_lost` 0, both counters 0. `clr_rx_rdy` is 0 whenever `rx_rdy` is 0.
- **Power-up latency:** GO consumed in cycle N in IDLE gives `pwr_up` = 1 and `auth_state` = 1 from cycle N+1.
- **Power-down latency:** a STOP with `roff_db` high in cycle N gives `pwr_up` = 0 from N+1.
- **Debounce latency:** `rider_off` rising in cycle N, held high, gives `roff_db` high in cycle N+`RIDER_OFF_CYC`. A DISCONNECTED-to-IDLE transition is then visible at N+`RIDER_OFF_CYC`+1.
- **Watchdog latency:** the last byte consumed or CONNECTED entry in cycle N, followed by silence, gives DISCONNECTED from cycle N+`TIMEOUT_CYC`.
- **Reset mid-operation:** asserting `rst_n` low drops `pwr_up` asynchronously and clears all state. After release, a new GO is required.

## Configuration
- `AUTH_LINK_WDOG_EN` defined: the watchdog counter and `link_lost` logic are compiled in as described above.
- `AUTH_LINK_WDOG_EN` undefined: no watchdog counter is built and `link_lost` is tied to 0. CONNECTED is left only by STOP. `TIMEOUT_CYC` is ignored.

## Test plan
Test parameters: `RIDER_OFF_CYC`=4, `TIMEOUT_CYC`=100, `AUTH_LINK_WDOG_EN` defined.

- **Power-up:** reset, then byte `8'h47` with `rx_rdy` high for one cycle -> `clr_rx_rdy` pulses that cycle; `pwr_up` and `auth_state`=1 the next cycle.
- **Stop while riding:** CONNECTED, `rider_off`=0, byte `8'h53` -> `auth_state`=2 and `pwr_up` stays 1. Then `rider_off`=1 for 4 cycles -> `auth_state`=0 and `pwr_up`=0 one cycle later.
- **Debounce rejection:** CONNECTED, `rider_off` high for 3 cycles then low, then `8'h53` -> DISCONNECTED, not IDLE.
- **Byte filtering:** IDLE, bytes `8'h00`, `8'h53`, `8'hFF` -> each consumed; state stays IDLE and `pwr_up`=0.
- **Watchdog:**
  - CONNECTED with 99 silent cycles -> still CONNECTED.
  - 100th silent cycle -> DISCONNECTED and `link_lost`=1.
  - Then `8'h47` -> CONNECTED and `link_lost`=0.
  - A byte on cycle 99 instead restarts the count.
- **Reset mid-session:** CONNECTED, `rst_n` low for 1 cycle -> `pwr_up`=0 immediately and `auth_state`=0 after release.
